// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard and stall controller: load-use and MDU-busy interlocks, branch squash
// strobes, and a saturating stall-cycle counter for performance analysis.
module hazard_stall_ctrl #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rd,
    input  logic        id_mdu_start,
    input  logic        id_mdu_div,
    input  logic        id_mdu_read,
    input  logic        id_branch_taken,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        mdu_busy,
    output logic [31:0] stall_cnt
);

    localparam logic [5:0]  MUL_LOAD = 6'(MUL_CYCLES);
    localparam logic [5:0]  DIV_LOAD = 6'(DIV_CYCLES);
    localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;

    logic [5:0]  mdu_cnt_reg, mdu_cnt_next;
    logic [31:0] stall_cnt_reg, stall_cnt_next;

    logic [4:0]  src_reg [2];
    logic [1:0]  src_use;
    logic [1:0]  src_hit;
    logic        lu_hazard;
    logic        mdu_hazard;
    logic        stall;

    assign src_reg[0] = id_rs;
    assign src_reg[1] = id_rt;
    assign src_use    = {id_use_rt, id_use_rs};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = src_use[gi] & (src_reg[gi] == ex_rd);
        end
    endgenerate

    // r0 is hardwired to zero, so a load targeting it never produces a dependency.
    assign lu_hazard  = ex_memread & (ex_rd != 5'd0) & (|src_hit);
    assign mdu_hazard = (mdu_cnt_reg != 6'd0) & (id_mdu_read | id_mdu_start);
    assign stall      = lu_hazard | mdu_hazard;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mdu_cnt_reg   <= 6'd0;
            stall_cnt_reg <= 32'd0;
        end else begin
            mdu_cnt_reg   <= mdu_cnt_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    // A held issue retries every cycle; it lands in the first cycle the counter reads zero.
    always_comb begin
        mdu_cnt_next = mdu_cnt_reg;
        if (id_mdu_start && !stall) begin
            mdu_cnt_next = id_mdu_div ? DIV_LOAD : MUL_LOAD;
        end else if (mdu_cnt_reg != 6'd0) begin
            mdu_cnt_next = mdu_cnt_reg - 6'd1;
        end

        stall_cnt_next = stall_cnt_reg;
        if (stall && (stall_cnt_reg != CNT_MAX)) begin
            stall_cnt_next = stall_cnt_reg + 32'd1;
        end
    end

    // Flush is held off while stalled: branch operands may be stale until the stall clears.
    always_comb begin
        pc_en       = ~stall;
        ifid_en     = ~stall;
        idex_bubble = stall;
        ifid_flush  = id_branch_taken & ~stall;
        mdu_busy    = (mdu_cnt_reg != 6'd0);
        stall_cnt   = stall_cnt_reg;
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios then random traffic, each cycle compared
// against a behavioural model of the interlock rules.
module tb_hazard_stall_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic        id_use_rs, id_use_rt, ex_memread;
    logic        id_mdu_start, id_mdu_div, id_mdu_read, id_branch_taken;
    logic        pc_en, ifid_en, ifid_flush, idex_bubble, mdu_busy;
    logic [31:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // model state: remaining MDU busy cycles and accumulated stall cycles
    int     m_mdu   = 0;
    longint m_stall = 0;
    bit     m_stall_now;

    hazard_stall_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_memread(ex_memread), .ex_rd(ex_rd),
        .id_mdu_start(id_mdu_start), .id_mdu_div(id_mdu_div),
        .id_mdu_read(id_mdu_read), .id_branch_taken(id_branch_taken),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .mdu_busy(mdu_busy), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; ex_rd = 0;
        id_use_rs = 0; id_use_rt = 0; ex_memread = 0;
        id_mdu_start = 0; id_mdu_div = 0; id_mdu_read = 0; id_branch_taken = 0;
    endtask

    function automatic bit model_stall();
        bit lu;
        lu = ex_memread && (ex_rd != 0) &&
             ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
        return lu || (m_mdu > 0 && (id_mdu_read || id_mdu_start));
    endfunction

    // Called just after a negedge with inputs applied: compare, then advance across one posedge.
    task automatic cycle(string tag);
        #1;
        m_stall_now = model_stall();
        chk({tag, ".pc_en"},       32'(pc_en),       32'(!m_stall_now));
        chk({tag, ".ifid_en"},     32'(ifid_en),     32'(!m_stall_now));
        chk({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(m_stall_now));
        chk({tag, ".ifid_flush"},  32'(ifid_flush),  32'(id_branch_taken && !m_stall_now));
        chk({tag, ".mdu_busy"},    32'(mdu_busy),    32'(m_mdu > 0));
        chk({tag, ".stall_cnt"},   stall_cnt,        32'(m_stall));
        $display("cycle %-10s stall=%0d pc_en=%0d flush=%0d mdu_left=%0d stall_cnt=%0h",
                 tag, m_stall_now, pc_en, ifid_flush, m_mdu, stall_cnt);
        @(posedge clk);
        if (id_mdu_start && !m_stall_now) m_mdu = id_mdu_div ? 32 : 4;
        else if (m_mdu > 0)               m_mdu--;
        if (m_stall_now && m_stall < 64'hFFFF_FFFF) m_stall++;
        @(negedge clk);
    endtask

    initial begin
        int n;
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        cycle("reset");
        rst = 1'b0;
        cycle("idle");

        // load-use on rs, then the load leaves EX
        ex_memread = 1; ex_rd = 8; id_rs = 8; id_use_rs = 1;
        cycle("lu");
        chk("lu.stall_cnt_after", stall_cnt, 32'd1);
        clear_inputs();
        cycle("lu_clear");
        ex_memread = 1; ex_rd = 0; id_rs = 0; id_use_rs = 1;
        cycle("lu_r0");
        ex_memread = 1; ex_rd = 9; id_rt = 9; id_use_rt = 1; id_rs = 9; id_use_rs = 0;
        cycle("lu_rt");
        clear_inputs();

        // multiply then dependent mfhi
        id_mdu_start = 1; id_mdu_div = 0;
        cycle("mul");
        clear_inputs();
        id_mdu_read = 1;
        n = 0;
        while (model_stall() && n < 10) begin n++; cycle("mfhi"); end
        chk("mfhi.stall_cycles", 32'(n), 32'd4);
        chk("mfhi.stall_cnt", stall_cnt, 32'd6);
        cycle("mfhi_go");
        clear_inputs();

        // divide then mult held behind it
        id_mdu_start = 1; id_mdu_div = 1;
        cycle("div");
        id_mdu_div = 0;
        n = 0;
        while (model_stall() && n < 40) begin n++; cycle("mul_wait"); end
        chk("div.stall_cycles", 32'(n), 32'd32);
        cycle("mul_issue");
        clear_inputs();
        n = 0;
        while (m_mdu > 0 && n < 10) begin n++; cycle("mul_busy"); end
        chk("mul_after_div.busy_cycles", 32'(n), 32'd4);
        cycle("mdu_idle");

        // taken branch alone, then coincident with load-use
        id_branch_taken = 1;
        cycle("br");
        ex_memread = 1; ex_rd = 3; id_rs = 3; id_use_rs = 1;
        cycle("br_lu");
        ex_memread = 0;
        cycle("br_retry");
        clear_inputs();

        // asynchronous reset mid-divide with the counter at 17
        id_mdu_start = 1; id_mdu_div = 1;
        cycle("div2");
        clear_inputs();
        repeat (15) cycle("div2_run");
        chk("div2.model_left", 32'(m_mdu), 32'd17);
        #2 rst = 1'b1;
        #1;
        chk("arst.mdu_busy", 32'(mdu_busy), 32'd0);
        chk("arst.stall_cnt", stall_cnt, 32'd0);
        chk("arst.pc_en", 32'(pc_en), 32'd1);
        m_mdu = 0; m_stall = 0;
        @(negedge clk);
        rst = 1'b0;
        cycle("post_arst");

        // saturation: backdoor the counter close to the top, then keep stalling
        force dut.stall_cnt_reg = 32'hFFFF_FFFD;
        #1 release dut.stall_cnt_reg;
        m_stall = 64'hFFFF_FFFD;
        ex_memread = 1; ex_rd = 5; id_rt = 5; id_use_rt = 1;
        repeat (4) cycle("sat");
        chk("sat.final", stall_cnt, 32'hFFFF_FFFF);
        clear_inputs();
        rst = 1'b1;
        #1 m_mdu = 0; m_stall = 0;
        @(negedge clk);
        rst = 1'b0;

        // random traffic on a small register range to force collisions
        for (int i = 0; i < 400; i++) begin
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            ex_rd           = 5'($urandom_range(0, 3));
            id_use_rs       = 1'($urandom);
            id_use_rt       = 1'($urandom);
            ex_memread      = ($urandom_range(0, 2) == 0);
            id_mdu_start    = ($urandom_range(0, 9) == 0);
            id_mdu_div      = 1'($urandom);
            id_mdu_read     = ($urandom_range(0, 3) == 0);
            id_branch_taken = ($urandom_range(0, 4) == 0);
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard and stall controller in the ID stage of the 5-stage CPU. It generates the PC-hold signal (`pc_en`, the nostall input of the PC/IF register) and the IF/ID and ID/EX control strobes. It tracks load-use hazards, the multi-cycle multiply/divide unit (MDU) busy window, and taken-branch squashing. A saturating counter records stall cycles for performance analysis.

## Interface
Parameters:
- `MUL_CYCLES`, default 4: MDU busy cycles after a mult/multu issue; legal range 1..63.
- `DIV_CYCLES`, default 32: MDU busy cycles after a div/divu issue; legal range 1..63.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `id_rs`, `id_rt` in 5: source register numbers of the instruction in ID.
- `id_use_rs`, `id_use_rt` in 1: ID instruction actually reads rs / rt.
- `ex_memread` in 1: instruction in EX is a load.
- `ex_rd` in 5: destination register of the instruction in EX.
- `id_mdu_start` in 1: ID instruction is mult/multu/div/divu.
- `id_mdu_div` in 1: qualifies `id_mdu_start`; 1 = divide, 0 = multiply.
- `id_mdu_read` in 1: ID instruction is mfhi/mflo/mthi/mtlo.
- `id_branch_taken` in 1: branch or jump in ID resolved taken.
- `pc_en` out 1: 1 = PC loads NPC; 0 = PC holds.
- `ifid_en` out 1: IF/ID register load enable.
- `ifid_flush` out 1: clear IF/ID to a nop at the next edge.
- `idex_bubble` out 1: load a nop into ID/EX at the next edge.
- `mdu_busy` out 1: MDU counter non-zero.
- `stall_cnt` out 32: saturating count of stall cycles.

## Operation
- `lu_hazard` = `ex_memread` & (`ex_rd` != 0) & ((`id_use_rs` & `id_rs` == `ex_rd`) | (`id_use_rt` & `id_rt` == `ex_rd`)).
- `mdu_hazard` = (`mdu_cnt` != 0) & (`id_mdu_read` | `id_mdu_start`).
- `stall` = `lu_hazard` | `mdu_hazard`.
- Outputs:
  - `pc_en` = `ifid_en` = ~`stall`.
  - `idex_bubble` = `stall`.
  - `ifid_flush` = `id_branch_taken` & ~`stall`.
- Priority: a stall suppresses the flush. The branch is re-evaluated when the stall clears, because its operands may be stale while stalled.
- MDU counter `mdu_cnt` (6 bits), two states:
  - IDLE: `mdu_cnt` == 0.
  - BUSY: `mdu_cnt` != 0.
- Issue accepted when `id_mdu_start` & ~`stall`. `mdu_cnt` <= `id_mdu_div` ? `DIV_CYCLES` : `MUL_CYCLES`.
- Otherwise, if `mdu_cnt` != 0, `mdu_cnt` decrements by 1 each cycle. No wrap below 0.
- A new issue while BUSY is itself a hazard. It stalls until the cycle in which `mdu_cnt` == 0, then is accepted in that cycle.
- `mdu_busy` = (`mdu_cnt` != 0).
- `stall_cnt` increments by 1 on every edge where `stall` = 1. It saturates at 32'hFFFF_FFFF and does not wrap.
- Register 0 is never a hazard source.

## Timing
- All hazard outputs are combinational from the current inputs and registered state. The stall takes effect at the same edge it is detected, with zero added latency.
- Reset (async, any time, including mid-BUSY): `mdu_cnt` = 0 and `stall_cnt` = 0 immediately. With request inputs low:
  - `pc_en` = 1, `ifid_en` = 1.
  - `ifid_flush` = 0, `idex_bubble` = 0.
  - `mdu_busy` = 0, `stall_cnt` = 0.
- Load-use stall lasts exactly 1 cycle, since the load leaves EX after the held edge.
- Multiply issued at edge E0:
  - `mdu_cnt` = 4, 3, 2, 1 in the four cycles after E0.
  - It is 0 in the fifth cycle.
  - A dependent mfhi arriving in ID right after E0 stalls 4 cycles and proceeds in the fifth.
- Simultaneous load-use and MDU hazard: one stall cycle is counted once in `stall_cnt`.
- Simultaneous `id_mdu_start` and `lu_hazard`: the issue is not accepted and `mdu_cnt` is unchanged.

## Test plan
- Reset mid-divide (`mdu_cnt` = 17), assert `rst` asynchronously between edges:
  - `mdu_busy` and `stall_cnt` drop to 0 before the next edge.
  - `pc_en` = 1.
- Load-use: `ex_memread` = 1, `ex_rd` = 8, `id_rs` = 8, `id_use_rs` = 1:
  - `pc_en` = 0 and `idex_bubble` = 1 for 1 cycle.
  - `stall_cnt` = 1.
  - Repeat with `ex_rd` = 0: no stall.
- Multiply followed by mfhi in the next ID cycle (`MUL_CYCLES` = 4):
  - `pc_en` = 0 for exactly 4 cycles, then 1.
  - `stall_cnt` = 4.
- Divide (`DIV_CYCLES` = 32) followed by mult in the next ID cycle:
  - Stall for 32 cycles.
  - The mult is accepted in the cycle `mdu_cnt` == 0; `mdu_cnt` then reads 4.
- Taken branch with no hazard: `ifid_flush` = 1 for 1 cycle and `pc_en` = 1. Taken branch coincident with load-use: `ifid_flush` = 0 while stalled, then 1 in the following cycle.
- Force `stall_cnt` near saturation (preload via 2^32-2 stall cycles, or backdoor): the count stops at 32'hFFFF_FFFF with no wrap.
